synth_method_arbiter: RTL

- Shares one Synthesijer-generated method port (req/busy/return handshake, two argument inputs) between N_REQ client requesters.
- Round-robin arbitration; sequences each call through issue, start, run and complete; returns the result and an error flag to the winning client.
- Sits between client FSMs (or a testbench driver) and a generated compute module such as a sum/get/test method instance.
- Start and run watchdogs stop a hung method from deadlocking all clients.

---
 rtl/synth_arb_pkg.sv | 15 +
 rtl/synth_method_arbiter_rr_pick.sv | 36 +++
 rtl/synth_method_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/synth_arb_pkg.sv
// Shared types and widths for the method-port arbiter.
package synth_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    RESPOND
  } arb_state_t;

  localparam int TIMEOUT_W = 16;
  localparam int WDOG_W    = 32;

endpackage

// File: rtl/synth_method_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request bit searching
// upward from last_grant+1, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  // candidate index for each search offset (offset gi+1 from last_grant)
  logic [IDX_W:0]   cand_sum [N_REQ];
  logic [IDX_W-1:0] cand_idx [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    assign cand_sum[gi] = {1'b0, last_grant} + (IDX_W+1)'(gi + 1);
    assign cand_idx[gi] = (cand_sum[gi] >= (IDX_W+1)'(N_REQ))
                          ? IDX_W'(cand_sum[gi] - (IDX_W+1)'(N_REQ))
                          : cand_sum[gi][IDX_W-1:0];
  end

  // scan from the farthest offset down so the nearest requester wins
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[cand_idx[i]]) begin
        valid = 1'b1;
        index = cand_idx[i];
      end
    end
  end

endmodule

// File: rtl/synth_method_arbiter.sv
// Round-robin arbiter sharing one generated-method port (req/busy/return)
// between N_REQ clients, with start and run watchdogs.
module synth_method_arbiter
  import synth_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int W        = 32,
  parameter int START_TO = 8,
  parameter int RUN_TO   = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     cli_req,
  input  logic [N_REQ*W-1:0]   cli_arg0,
  input  logic [N_REQ*W-1:0]   cli_arg1,
  output logic [N_REQ-1:0]     cli_ack,
  output logic [N_REQ-1:0]     cli_done,
  output logic [W-1:0]         cli_result,
  output logic                 cli_err,
  output logic                 m_req,
  output logic [W-1:0]         m_arg0,
  output logic [W-1:0]         m_arg1,
  input  logic                 m_busy,
  input  logic [W-1:0]         m_return,
  output logic                 busy,
  output logic [TIMEOUT_W-1:0] timeout_count
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t           state_reg, state_next;
  logic [IDX_W-1:0]     last_grant_reg, last_grant_next;
  logic [IDX_W-1:0]     cur_reg, cur_next;
  logic [WDOG_W-1:0]    wdog_reg, wdog_next;
  logic [N_REQ-1:0]     ack_reg, ack_next;
  logic [N_REQ-1:0]     done_reg, done_next;
  logic [W-1:0]         result_reg, result_next;
  logic                 err_reg, err_next;
  logic                 m_req_reg, m_req_next;
  logic [W-1:0]         arg0_reg, arg0_next;
  logic [W-1:0]         arg1_reg, arg1_next;
  logic [TIMEOUT_W-1:0] tcount_reg, tcount_next;

  logic [W-1:0]         arg0_arr [N_REQ];
  logic [W-1:0]         arg1_arr [N_REQ];
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign arg0_arr[gi] = cli_arg0[gi*W +: W];
    assign arg1_arr[gi] = cli_arg1[gi*W +: W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (cli_req),
    .last_grant (last_grant_reg),
    .valid      (pick_valid),
    .index      (pick_idx)
  );

  // next-state and next-output logic; pulse outputs default low every cycle
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    cur_next        = cur_reg;
    wdog_next       = wdog_reg;
    ack_next        = '0;
    done_next       = '0;
    result_next     = '0;
    err_next        = 1'b0;
    m_req_next      = 1'b0;
    arg0_next       = arg0_reg;
    arg1_next       = arg1_reg;
    tcount_next     = tcount_reg;

    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          ack_next   = N_REQ'(1) << pick_idx;
          arg0_next  = arg0_arr[pick_idx];
          arg1_next  = arg1_arr[pick_idx];
          cur_next   = pick_idx;
          m_req_next = 1'b1;  // registered, so it is high during ISSUE
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        wdog_next  = '0;
        state_next = WAIT_START;
      end
      WAIT_START: begin
        if (m_busy) begin
          wdog_next  = '0;
          state_next = WAIT_DONE;
        end else if (START_TO != 0 && wdog_reg == WDOG_W'(START_TO)) begin
          done_next  = N_REQ'(1) << cur_reg;
          err_next   = 1'b1;
          state_next = RESPOND;
        end else begin
          wdog_next = wdog_reg + WDOG_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!m_busy) begin
          done_next   = N_REQ'(1) << cur_reg;
          result_next = m_return;
          state_next  = RESPOND;
        end else if (RUN_TO != 0 && wdog_reg == WDOG_W'(RUN_TO)) begin
          done_next  = N_REQ'(1) << cur_reg;
          err_next   = 1'b1;
          state_next = RESPOND;
        end else begin
          wdog_next = wdog_reg + WDOG_W'(1);
        end
      end
      RESPOND: begin
        last_grant_next = cur_reg;
        if (err_reg && tcount_reg != '1) begin
          tcount_next = tcount_reg + TIMEOUT_W'(1);
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // state and output registers; reset aborts any call in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= IDX_W'(N_REQ - 1);
      cur_reg        <= '0;
      wdog_reg       <= '0;
      ack_reg        <= '0;
      done_reg       <= '0;
      result_reg     <= '0;
      err_reg        <= 1'b0;
      m_req_reg      <= 1'b0;
      arg0_reg       <= '0;
      arg1_reg       <= '0;
      tcount_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      cur_reg        <= cur_next;
      wdog_reg       <= wdog_next;
      ack_reg        <= ack_next;
      done_reg       <= done_next;
      result_reg     <= result_next;
      err_reg        <= err_next;
      m_req_reg      <= m_req_next;
      arg0_reg       <= arg0_next;
      arg1_reg       <= arg1_next;
      tcount_reg     <= tcount_next;
    end
  end

  assign cli_ack       = ack_reg;
  assign cli_done      = done_reg;
  assign cli_result    = result_reg;
  assign cli_err       = err_reg;
  assign m_req         = m_req_reg;
  assign m_arg0        = arg0_reg;
  assign m_arg1        = arg1_reg;
  assign busy          = (state_reg != IDLE);
  assign timeout_count = tcount_reg;

endmodule
